ins_cache_nway: RTL and testbench



---
 rtl/ins_cache_nway.sv | 185 ++++++++++++++++++
 tb/tb_ins_cache_nway.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ins_cache_nway.sv
// N-way set-associative instruction cache model driven by trace commands.
// True-LRU per set, next-level line fetch over req/ack, saturating statistics.
module ins_cache_nway #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned OFFSET_BITS = 6,
    parameter int unsigned SET_BITS    = 14,
    parameter int unsigned WAYS        = 2,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [3:0]                    n,
    input  logic [ADDR_W-1:0]             add_in,
    output logic [ADDR_W-OFFSET_BITS-1:0] add_out,
    output logic                          l2_req,
    input  logic                          l2_ack,
    output logic                          rsp_valid,
    output logic                          rsp_hit,
    output logic [CNT_W-1:0]              hit,
    output logic [CNT_W-1:0]              miss,
    output logic [CNT_W-1:0]              reads
);
    localparam int unsigned SETS   = 1 << SET_BITS;
    localparam int unsigned LINE_W = ADDR_W - OFFSET_BITS;
    localparam int unsigned TAG_W  = LINE_W - SET_BITS;
    localparam int unsigned LRU_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {StClear, StIdle, StLookup, StFill} state_e;

    state_e              state_q;
    logic [SET_BITS-1:0] clr_idx_q;
    logic [LINE_W-1:0]   line_q;
    logic                fetch_q;
    logic [LRU_W-1:0]    victim_q;

    logic [WAYS-1:0]  valid_q [SETS];
    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [LRU_W-1:0] age_q   [SETS][WAYS];

    logic [SET_BITS-1:0] set_idx;
    logic [TAG_W-1:0]    set_tag;
    logic                lookup_hit;
    logic [LRU_W-1:0]    hit_way;
    logic [LRU_W-1:0]    victim;
    logic                free_found;
    logic [LRU_W-1:0]    touch_way;
    logic [LRU_W-1:0]    touched_age [WAYS];
    logic                unused_offset;

    assign set_idx       = line_q[SET_BITS-1:0];
    assign set_tag       = line_q[LINE_W-1:SET_BITS];
    assign cmd_ready     = (state_q == StIdle);
    assign unused_offset = ^add_in[OFFSET_BITS-1:0];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        lookup_hit = 1'b0;
        hit_way    = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[set_idx][w] && (tag_q[set_idx][w] == set_tag)) begin
                lookup_hit = 1'b1;
                hit_way    = LRU_W'(w);
            end
        end
    end

    // Prefer the lowest free way; only evict the LRU (age 0) way when the set is full.
    always_comb begin
        victim     = '0;
        free_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!free_found && !valid_q[set_idx][w]) begin
                victim     = LRU_W'(w);
                free_found = 1'b1;
            end
        end
        if (!free_found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[set_idx][w] == '0) begin
                    victim = LRU_W'(w);
                end
            end
        end
    end

    assign touch_way = (state_q == StFill) ? victim_q : hit_way;

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            if (LRU_W'(w) == touch_way) begin
                touched_age[w] = LRU_W'(WAYS - 1);
            end else if (age_q[set_idx][w] > age_q[set_idx][touch_way]) begin
                touched_age[w] = age_q[set_idx][w] - LRU_W'(1);
            end else begin
                touched_age[w] = age_q[set_idx][w];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StClear;
            clr_idx_q <= '0;
            hit       <= '0;
            miss      <= '0;
            reads     <= '0;
            rsp_valid <= 1'b0;
            rsp_hit   <= 1'b0;
            l2_req    <= 1'b0;
            add_out   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state_q)
                StClear: begin
                    valid_q[clr_idx_q] <= '0;
                    for (int w = 0; w < WAYS; w++) begin
                        age_q[clr_idx_q][w] <= LRU_W'(w);
                    end
                    clr_idx_q <= clr_idx_q + SET_BITS'(1);
                    if (&clr_idx_q) begin
                        state_q <= StIdle;
                    end
                end
                StIdle: begin
                    if (cmd_valid) begin
                        line_q  <= add_in[ADDR_W-1:OFFSET_BITS];
                        fetch_q <= (n == 4'd2);
                        case (n)
                            4'd2, 4'd3: state_q <= StLookup;
                            4'd8: begin
                                hit       <= '0;
                                miss      <= '0;
                                reads     <= '0;
                                clr_idx_q <= '0;
                                state_q   <= StClear;
                            end
                            default: ;
                        endcase
                    end
                end
                StLookup: begin
                    state_q <= StIdle;
                    if (fetch_q) begin
                        reads <= sat_inc(reads);
                        if (lookup_hit) begin
                            hit <= sat_inc(hit);
                            for (int w = 0; w < WAYS; w++) begin
                                age_q[set_idx][w] <= touched_age[w];
                            end
                            rsp_valid <= 1'b1;
                            rsp_hit   <= 1'b1;
                        end else begin
                            miss     <= sat_inc(miss);
                            victim_q <= victim;
                            add_out  <= line_q;
                            l2_req   <= 1'b1;
                            state_q  <= StFill;
                        end
                    end else if (lookup_hit) begin
                        valid_q[set_idx][hit_way] <= 1'b0;
                    end
                end
                StFill: begin
                    if (l2_ack) begin
                        tag_q[set_idx][victim_q]   <= set_tag;
                        valid_q[set_idx][victim_q] <= 1'b1;
                        for (int w = 0; w < WAYS; w++) begin
                            age_q[set_idx][w] <= touched_age[w];
                        end
                        l2_req    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_hit   <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ins_cache_nway.sv
// Randomized and directed bench for ins_cache_nway against a recency-list cache model.
module tb_ins_cache_nway;
    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned OFFSET_BITS = 6;
    localparam int unsigned SET_BITS    = 2;
    localparam int unsigned WAYS        = 2;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned SETS        = 1 << SET_BITS;
    localparam int unsigned LINE_W      = ADDR_W - OFFSET_BITS;
    localparam int          CNT_MAX     = (1 << CNT_W) - 1;
    localparam int          TMO         = 64;

    typedef logic [LINE_W-1:0] line_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [3:0]        n = 4'd0;
    logic [ADDR_W-1:0] add_in = '0;
    logic [LINE_W-1:0] add_out;
    logic              l2_req;
    logic              l2_ack = 1'b0;
    logic              rsp_valid;
    logic              rsp_hit;
    logic [CNT_W-1:0]  hit;
    logic [CNT_W-1:0]  miss;
    logic [CNT_W-1:0]  reads;

    ins_cache_nway #(
        .ADDR_W     (ADDR_W),
        .OFFSET_BITS(OFFSET_BITS),
        .SET_BITS   (SET_BITS),
        .WAYS       (WAYS),
        .CNT_W      (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .n        (n),
        .add_in   (add_in),
        .add_out  (add_out),
        .l2_req   (l2_req),
        .l2_ack   (l2_ack),
        .rsp_valid(rsp_valid),
        .rsp_hit  (rsp_hit),
        .hit      (hit),
        .miss     (miss),
        .reads    (reads)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: each set is a list of resident lines ordered LRU first.
    line_t mset [SETS][$];
    int    m_hit, m_miss, m_reads;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v < CNT_MAX) ? v + 1 : v;
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < int'(SETS); s++) mset[s].delete();
        m_hit   = 0;
        m_miss  = 0;
        m_reads = 0;
    endfunction

    function automatic bit model_fetch(input line_t line);
        int s;
        int pos;
        s   = int'(line[SET_BITS-1:0]);
        pos = -1;
        for (int i = 0; i < mset[s].size(); i++) if (mset[s][i] == line) pos = i;
        if (pos >= 0) mset[s].delete(pos);
        else if (mset[s].size() == int'(WAYS)) mset[s].delete(0);
        mset[s].push_back(line);
        m_reads = sat(m_reads);
        if (pos >= 0) m_hit = sat(m_hit);
        else m_miss = sat(m_miss);
        return pos >= 0;
    endfunction

    function automatic void model_inval(input line_t line);
        int s;
        int pos;
        s   = int'(line[SET_BITS-1:0]);
        pos = -1;
        for (int i = 0; i < mset[s].size(); i++) if (mset[s][i] == line) pos = i;
        if (pos >= 0) mset[s].delete(pos);
    endfunction

    task automatic check_counters(input string tag);
        check_eq({tag, "_hit"}, 32'(hit), 32'(m_hit));
        check_eq({tag, "_miss"}, 32'(miss), 32'(m_miss));
        check_eq({tag, "_reads"}, 32'(reads), 32'(m_reads));
    endtask

    // Returns just after the transfer edge.
    task automatic send(input logic [3:0] code, input logic [31:0] addr);
        int cyc = 0;
        @(negedge clk);
        while (!cmd_ready && cyc < TMO) begin
            @(negedge clk);
            cyc++;
        end
        if (!cmd_ready) check_eq("ready_timeout", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        n         = code;
        add_in    = addr;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic expect_clear(input string tag);
        int cnt = 0;
        @(negedge clk);
        check_eq({tag, "_l2_req"}, 32'(l2_req), 32'd0);
        check_counters(tag);
        while (!cmd_ready && cnt < TMO) begin
            cnt++;
            @(negedge clk);
        end
        check_eq({tag, "_len"}, 32'(cnt), 32'(SETS));
    endtask

    task automatic fetch(input logic [31:0] addr, input int delay, output bit got);
        bit exp_hit;
        bit held;
        exp_hit = model_fetch(addr[ADDR_W-1:OFFSET_BITS]);
        send(4'd2, addr);
        repeat (2) @(negedge clk);
        got = rsp_valid && rsp_hit;
        if (exp_hit) begin
            check_eq("hit_rsp_valid", 32'(rsp_valid), 32'd1);
            check_eq("hit_rsp_hit", 32'(rsp_hit), 32'd1);
            if (l2_req) begin
                l2_ack = 1'b1;
                @(posedge clk);
                #1 l2_ack = 1'b0;
                @(negedge clk);
            end
        end else begin
            check_eq("miss_l2_req", 32'(l2_req), 32'd1);
            check_eq("miss_add_out", 32'(add_out), 32'(addr[ADDR_W-1:OFFSET_BITS]));
            held = 1'b1;
            for (int i = 0; i < delay; i++) begin
                @(negedge clk);
                if (l2_req !== 1'b1 || add_out !== addr[ADDR_W-1:OFFSET_BITS]) held = 1'b0;
            end
            check_eq("fill_hold", 32'(held), 32'd1);
            l2_ack = 1'b1;
            @(posedge clk);
            #1 l2_ack = 1'b0;
            @(negedge clk);
            check_eq("fill_rsp_valid", 32'(rsp_valid), 32'd1);
            check_eq("fill_rsp_hit", 32'(rsp_hit), 32'd0);
            check_eq("fill_l2_req", 32'(l2_req), 32'd0);
        end
        check_counters("fetch");
    endtask

    task automatic inval(input logic [31:0] addr);
        model_inval(addr[ADDR_W-1:OFFSET_BITS]);
        send(4'd3, addr);
        repeat (2) @(negedge clk);
        check_eq("inval_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("inval_ready", 32'(cmd_ready), 32'd1);
        check_counters("inval");
    endtask

    task automatic nop_cmd(input logic [3:0] code, input logic [31:0] addr);
        send(code, addr);
        @(negedge clk);
        check_eq("nop_ready", 32'(cmd_ready), 32'd1);
        check_counters("nop");
    endtask

    task automatic clear_cmd();
        model_clear();
        send(4'd8, 32'd0);
        expect_clear("clear");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          got;
        int          r;
        logic [3:0]  code;
        logic [31:0] addr;

        model_clear();
        cmd_valid = 1'b1;
        n         = 4'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        expect_clear("reset");
        cmd_valid = 1'b0;

        fetch(32'h0000_1000, 3, got);
        check_eq("first_miss", 32'(got), 32'd0);
        fetch(32'h0000_1004, 0, got);
        check_eq("second_hit", 32'(got), 32'd1);
        check_eq("pair_hit", 32'(hit), 32'd1);
        check_eq("pair_miss", 32'(miss), 32'd1);
        check_eq("pair_reads", 32'(reads), 32'd2);

        clear_cmd();
        fetch(32'h000, 1, got);
        fetch(32'h100, 2, got);
        fetch(32'h000, 0, got);
        check_eq("lru_a_hit", 32'(got), 32'd1);
        fetch(32'h200, 1, got);
        check_eq("lru_c_miss", 32'(got), 32'd0);
        fetch(32'h000, 0, got);
        check_eq("lru_a_rehit", 32'(got), 32'd1);
        fetch(32'h100, 0, got);
        check_eq("lru_b_evicted", 32'(got), 32'd0);

        clear_cmd();
        fetch(32'h1000, 1, got);
        inval(32'h1000);
        check_eq("inv_hit", 32'(hit), 32'd0);
        check_eq("inv_miss", 32'(miss), 32'd1);
        check_eq("inv_reads", 32'(reads), 32'd1);
        fetch(32'h1000, 1, got);
        check_eq("inv_refetch_miss", 32'(got), 32'd0);
        check_eq("inv_miss2", 32'(miss), 32'd2);

        // Reset while a fill is outstanding, with a stray ack during the sweep.
        send(4'd2, 32'h5000);
        repeat (2) @(negedge clk);
        check_eq("rstfill_req_up", 32'(l2_req), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        l2_ack = 1'b1;
        model_clear();
        expect_clear("rstfill");
        l2_ack = 1'b0;
        fetch(32'h5000, 2, got);
        check_eq("rstfill_refetch_miss", 32'(got), 32'd0);

        clear_cmd();
        for (int i = 0; i < 17; i++) fetch(32'h3000 + 32'(i % 16) * 4, 1, got);
        check_eq("sat_miss", 32'(miss), 32'd1);
        check_eq("sat_hit", 32'(hit), 32'd15);
        check_eq("sat_reads", 32'(reads), 32'd15);
        clear_cmd();

        for (int i = 0; i < 300; i++) begin
            r    = int'($urandom_range(99));
            addr = ($urandom_range(5) << 8) | ($urandom_range(3) << 6) | $urandom_range(63);
            if (r < 65) begin
                fetch(addr, int'($urandom_range(4)), got);
            end else if (r < 85) begin
                inval(addr);
            end else if (r < 97) begin
                code = 4'($urandom_range(15));
                if (code == 4'd2 || code == 4'd3 || code == 4'd8) code = 4'd0;
                nop_cmd(code, addr);
            end else begin
                clear_cmd();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
